// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag and multiply-FSM types for alu_pipe
package alu_pkg;

    typedef enum logic [3:0] {
        OP_PASS_A = 4'h0,
        OP_PASS_B = 4'h1,
        OP_INC_A  = 4'h2,
        OP_INC_B  = 4'h3,
        OP_ADD    = 4'h4,
        OP_ADD_NB = 4'h5,
        OP_SUB    = 4'h6,
        OP_AND    = 4'h7,
        OP_MUL    = 4'h8,
        OP_OR     = 4'h9,
        OP_XOR    = 4'hA,
        OP_NOT_A  = 4'hB,
        OP_NOT_B  = 4'hC,
        OP_SHL    = 4'hD,
        OP_SHR    = 4'hE,
        OP_ZERO   = 4'hF
    } op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_MUL  = 2'd1,
        MS_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational op/flag evaluator used in the S2 stage
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output flags_t           flags
);

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_ci;
    logic [WIDTH:0]   sum;
    logic             add_v;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   shr;
    logic             c;
    logic             v;

    // All of ops 2-6 share one adder; only the operand and carry-in selection differs.
    always_comb begin
        add_x  = a;
        add_y  = '0;
        add_ci = 1'b0;
        case (op)
            OP_INC_A:  add_ci = 1'b1;
            OP_INC_B: begin
                add_x  = b;
                add_ci = 1'b1;
            end
            OP_ADD:    add_y = b;
            OP_ADD_NB: add_y = ~b;
            OP_SUB: begin
                add_y  = ~b;
                add_ci = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
    assign add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

    // The extra bit on each shifter catches the last bit shifted out (0 for a zero shift).
    assign sh  = b[SHW-1:0];
    assign shl = {1'b0, a} << sh;
    assign shr = {a, 1'b0} >> sh;

    always_comb begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_PASS_A: y = a;
            OP_PASS_B: y = b;
            OP_INC_A, OP_INC_B, OP_ADD, OP_ADD_NB, OP_SUB: begin
                y = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = add_v;
            end
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_NOT_A:  y = ~a;
            OP_NOT_B:  y = ~b;
            OP_SHL: begin
                y = shl[WIDTH-1:0];
                c = shl[WIDTH];
            end
            OP_SHR: begin
                y = shr[WIDTH:1];
                c = shr[0];
            end
            default: y = '0;
        endcase
    end

    assign flags = '{z: (y == '0), n: y[WIDTH-1], c: c, v: v};

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU; ALU_PIPE_MUL_EN adds iterative op-8 multiply
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic [WIDTH-1:0] core_y;
    flags_t           core_flags;
    flags_t           flags_q;
    logic             s2_load;
    logic             busy;

    alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
        .a     (s1_a),
        .b     (s1_b),
        .op    (s1_op),
        .y     (core_y),
        .flags (core_flags)
    );

    assign in_ready = !busy && (!s1_valid || s2_load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_PASS_A;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op_e'(select);
            end
        end
    end

`ifdef ALU_PIPE_MUL_EN
    mul_state_e         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;

    assign busy     = (state == MS_MUL);
    assign s2_load  = !busy && (!out_valid || out_ready);
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // The multiply takes over S2: one partial product per cycle, then DONE holds the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MS_IDLE;
            out_valid <= 1'b0;
            y         <= '0;
            flags_q   <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else if (state == MS_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == SHW'(WIDTH - 1)) begin
                state     <= MS_DONE;
                out_valid <= 1'b1;
                y         <= acc_next[WIDTH-1:0];
                flags_q   <= '{z: (acc_next[WIDTH-1:0] == '0), n: acc_next[WIDTH-1],
                               c: |acc_next[2*WIDTH-1:WIDTH], v: 1'b0};
            end
        end else if (s2_load) begin
            if (s1_valid && s1_op == OP_MUL) begin
                state     <= MS_MUL;
                out_valid <= 1'b0;
                acc       <= '0;
                mcand     <= {{WIDTH{1'b0}}, s1_a};
                mplier    <= s1_b;
                cnt       <= '0;
            end else begin
                state     <= MS_IDLE;
                out_valid <= s1_valid;
                if (s1_valid) begin
                    y       <= core_y;
                    flags_q <= core_flags;
                end
            end
        end
    end
`else
    assign busy    = 1'b0;
    assign s2_load = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            flags_q   <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y       <= core_y;
                flags_q <= core_flags;
            end
        end
    end
`endif

    assign flag_z = flags_q.z;
    assign flag_n = flags_q.n;
    assign flag_c = flags_q.c;
    assign flag_v = flags_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe at WIDTH=8 (honours ALU_PIPE_MUL_EN)
module tb_alu_pipe;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] y;
        logic [3:0]   f;
        int           c0;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   select = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] y;
    logic         flag_z, flag_n, flag_c, flag_v;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   saw_low;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 5000) begin
            $display("FAIL timeout: cycle %0d reached, limit 5000", cyc);
            $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
            $fatal(1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares the head of the scoreboard whenever a result is presented.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("y", 32'(y), 32'(q[0].y));
                check("flags_znvc", 32'({flag_z, flag_n, flag_c, flag_v}), 32'(q[0].f));
                if (out_ready) begin
                    if (q[0].lat != 0)
                        check("latency", 32'(cyc - q[0].c0), 32'(q[0].lat));
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [3:0] op,
                         input logic [W-1:0] ey, input logic [3:0] ef, input int lat);
        exp_t e;
        bit   done = 0;
        @(posedge clk);
        #1;
        a = ta;
        b = tb;
        select = op;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.y = ey;
                e.f = ef;
                e.c0 = cyc;
                e.lat = lat;
                q.push_back(e);
                done = 1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) check("accept_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        check("drain_remaining", 32'(q.size()), 32'd0);
    endtask

    initial begin
        // Reset state: flags listed as {z,n,c,v}
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Directed vectors, back to back with out_ready high
        issue(8'h7F, 8'h01, 4'h4, 8'h80, 4'b0101, 2);
        issue(8'h05, 8'h05, 4'h6, 8'h00, 4'b1010, 2);
        issue(8'h03, 8'h05, 4'h6, 8'hFE, 4'b0100, 2);
        issue(8'h81, 8'h01, 4'hE, 8'h40, 4'b0010, 2);
        issue(8'h81, 8'h03, 4'hD, 8'h08, 4'b0000, 2);
        issue(8'hFF, 8'h00, 4'h2, 8'h00, 4'b1010, 2);
        issue(8'h7F, 8'h00, 4'h2, 8'h80, 4'b0101, 2);
        issue(8'h3C, 8'h0F, 4'h7, 8'h0C, 4'b0000, 2);
        issue(8'h3C, 8'h0F, 4'h9, 8'h3F, 4'b0000, 2);
        issue(8'h3C, 8'h0F, 4'hA, 8'h33, 4'b0000, 2);
        issue(8'h3C, 8'h0F, 4'hB, 8'hC3, 4'b0100, 2);
        issue(8'h3C, 8'h0F, 4'hC, 8'hF0, 4'b0100, 2);
        issue(8'hA5, 8'h00, 4'h0, 8'hA5, 4'b0100, 2);
        issue(8'hA5, 8'h00, 4'h1, 8'h00, 4'b1000, 2);
        issue(8'h00, 8'hFF, 4'h3, 8'h00, 4'b1010, 2);
        issue(8'h05, 8'h05, 4'h5, 8'hFF, 4'b0100, 2);
        issue(8'h80, 8'h80, 4'h4, 8'h00, 4'b1011, 2);
        issue(8'h12, 8'h34, 4'hF, 8'h00, 4'b1000, 2);
        issue(8'h81, 8'h00, 4'hD, 8'h81, 4'b0100, 2);
        issue(8'h81, 8'h07, 4'hE, 8'h01, 4'b0000, 2);
        issue(8'hC0, 8'h07, 4'hE, 8'h01, 4'b0010, 2);
        idle(2);
        drain();

        // Four-op stream with a three-cycle downstream stall
        saw_low = 0;
        fork
            begin
                issue(8'h01, 8'h02, 4'h4, 8'h03, 4'b0000, 0);
                issue(8'h10, 8'h01, 4'h6, 8'h0F, 4'b0010, 0);
                issue(8'hF0, 8'h0F, 4'h9, 8'hFF, 4'b0100, 0);
                issue(8'h55, 8'hFF, 4'hA, 8'hAA, 4'b0100, 0);
                idle(1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (!in_ready) saw_low = 1;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("stall_in_ready_low", 32'(saw_low), 32'd1);
        drain();

        // Reset while two ops are in flight
        issue(8'h11, 8'h22, 4'h4, 8'h33, 4'b0000, 2);
        issue(8'h44, 8'h11, 4'h4, 8'h55, 4'b0000, 2);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        q.delete();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_y", 32'(y), 32'd0);
        check("midrst_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        issue(8'h20, 8'h03, 4'hD, 8'h00, 4'b1010, 2);
        idle(1);
        drain();

        // Op 8: iterative multiply when enabled, otherwise behaves as op F
`ifdef ALU_PIPE_MUL_EN
        issue(8'h10, 8'h11, 4'h8, 8'h10, 4'b0010, 10);
        idle(0);
        repeat (3) @(negedge clk);
        check("mul_in_ready_low", 32'(in_ready), 32'd0);
        issue(8'h0F, 8'h0F, 4'h8, 8'hE1, 4'b0100, 0);
        issue(8'h02, 8'h03, 4'h4, 8'h05, 4'b0000, 0);
        idle(1);
        drain();
`else
        issue(8'h10, 8'h11, 4'h8, 8'h00, 4'b1000, 2);
        issue(8'hFF, 8'hFF, 4'h8, 8'h00, 4'b1000, 2);
        idle(1);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
